// File: rtl/prog_sequencer_if.sv
// Host/core-facing signal bundle of the program sequencer.
// The master side is the host plus core (Go, Abort, table, Halt); the slave side is the sequencer.
interface prog_sequencer_if #(
    parameter int NUM_PROGS = 3,
    parameter int ADDR_W    = 8,
    parameter int CNT_W     = 16
);
    logic                        Go;
    logic                        Abort;
    logic [NUM_PROGS*ADDR_W-1:0] Addr_Table;
    logic                        Halt;
    logic                        Start;
    logic [ADDR_W-1:0]           Start_Addr;
    logic [2:0]                  Prog_Idx;
    logic                        Busy;
    logic                        Done_All;
    logic                        Timeout;
    logic [CNT_W-1:0]            Cycle_Count;
    logic [CNT_W-1:0]            Last_Cycles;

    modport master (
        output Go, Abort, Addr_Table, Halt,
        input  Start, Start_Addr, Prog_Idx, Busy, Done_All, Timeout, Cycle_Count, Last_Cycles
    );

    modport slave (
        input  Go, Abort, Addr_Table, Halt,
        output Start, Start_Addr, Prog_Idx, Busy, Done_All, Timeout, Cycle_Count, Last_Cycles
    );
endinterface

// File: rtl/prog_sequencer.sv
// Batch sequencer: launches each program of a latched address table on the
// fetch unit, waits for the core's Halt, and aborts programs that overrun a
// cycle budget. Every output is registered.
module prog_sequencer #(
    parameter int NUM_PROGS   = 3,
    parameter int ADDR_W      = 8,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             CLK,
    input  logic             Reset_n,
    prog_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, GAP, FIN} state_t;

    state_t                      state_reg, state_next;
    logic                        start_reg, start_next;
    logic [ADDR_W-1:0]           start_addr_reg, start_addr_next;
    logic [2:0]                  prog_idx_reg, prog_idx_next;
    logic                        busy_reg, busy_next;
    logic                        done_reg, done_next;
    logic                        timeout_reg, timeout_next;
    logic [CNT_W-1:0]            cycle_count_reg, cycle_count_next;
    logic [CNT_W-1:0]            last_cycles_reg, last_cycles_next;
    logic [NUM_PROGS*ADDR_W-1:0] table_reg, table_next;

    // Table view padded to 8 entries so the 3-bit program index always selects a legal slot.
    logic [ADDR_W-1:0] entry [8];

    // The table is re-latched only when Go is accepted; this is kept apart from the
    // FSM logic because the launch address of the very first program reads it.
    assign table_next = (state_reg == IDLE && bus.Go && !bus.Abort) ? bus.Addr_Table : table_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_entry
            if (gi < NUM_PROGS) begin : g_used
                assign entry[gi] = table_next[gi*ADDR_W +: ADDR_W];
            end else begin : g_pad
                assign entry[gi] = '0;
            end
        end
    endgenerate

    // Next-state and next-output logic.
    always_comb begin
        state_next       = state_reg;
        start_next       = 1'b0;
        start_addr_next  = start_addr_reg;
        prog_idx_next    = prog_idx_reg;
        done_next        = done_reg;
        timeout_next     = timeout_reg;
        cycle_count_next = cycle_count_reg;
        last_cycles_next = last_cycles_reg;

        case (state_reg)
            IDLE: begin
                if (bus.Go) begin
                    prog_idx_next = 3'd0;
                    done_next     = 1'b0;
                    timeout_next  = 1'b0;
                    state_next    = LAUNCH;
                end
            end
            LAUNCH: begin
                // Halt is deliberately ignored here: the core has not started yet.
                cycle_count_next = CNT_W'(1);
                state_next       = RUN;
            end
            RUN: begin
                // Halt is checked before the budget so a halt on the last allowed cycle is not a timeout.
                if (bus.Halt) begin
                    last_cycles_next = cycle_count_reg;
                    state_next       = (prog_idx_reg == 3'(NUM_PROGS - 1)) ? FIN : GAP;
                end else if (cycle_count_reg == CNT_W'(TIMEOUT_CYC)) begin
                    timeout_next     = 1'b1;
                    last_cycles_next = CNT_W'(TIMEOUT_CYC);
                    state_next       = (prog_idx_reg == 3'(NUM_PROGS - 1)) ? FIN : GAP;
                end else begin
                    cycle_count_next = cycle_count_reg + CNT_W'(1);
                end
            end
            GAP: begin
                // One dead cycle gives the core time to drop Halt before the next launch.
                prog_idx_next = prog_idx_reg + 3'd1;
                state_next    = LAUNCH;
            end
            FIN: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Abort beats every other event; debug state (index, last count, timeout flag) is frozen.
        if (bus.Abort) begin
            state_next       = IDLE;
            done_next        = 1'b0;
            prog_idx_next    = prog_idx_reg;
            timeout_next     = timeout_reg;
            last_cycles_next = last_cycles_reg;
            cycle_count_next = cycle_count_reg;
        end

        // Start and its address are produced one edge ahead so they appear exactly in LAUNCH.
        if (state_next == LAUNCH) begin
            start_next       = 1'b1;
            start_addr_next  = entry[prog_idx_next];
            cycle_count_next = '0;
        end

        busy_next = (state_next != IDLE);
    end

    // State and registered outputs, cleared immediately on reset.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg       <= IDLE;
            start_reg       <= 1'b0;
            start_addr_reg  <= '0;
            prog_idx_reg    <= 3'd0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            timeout_reg     <= 1'b0;
            cycle_count_reg <= '0;
            last_cycles_reg <= '0;
            table_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            start_reg       <= start_next;
            start_addr_reg  <= start_addr_next;
            prog_idx_reg    <= prog_idx_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            timeout_reg     <= timeout_next;
            cycle_count_reg <= cycle_count_next;
            last_cycles_reg <= last_cycles_next;
            table_reg       <= table_next;
        end
    end

    assign bus.Start       = start_reg;
    assign bus.Start_Addr  = start_addr_reg;
    assign bus.Prog_Idx    = prog_idx_reg;
    assign bus.Busy        = busy_reg;
    assign bus.Done_All    = done_reg;
    assign bus.Timeout     = timeout_reg;
    assign bus.Cycle_Count = cycle_count_reg;
    assign bus.Last_Cycles = last_cycles_reg;
endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Top-level controller that sequences the instruction-fetch unit through a batch of NUM_PROGS programs.
- For each program it pulses the fetch unit's Start with that program's start address, then waits for the core's Halt. It counts execution cycles and aborts any program that exceeds a cycle budget.
- Sits between the testbench/host handshake (Go / Done_All) and the fetch unit's Start / Start_Addr inputs.

Parameters:
- NUM_PROGS, 3, number of programs in a batch (1..8).
- ADDR_W, 8, instruction address width; matches PC width.
- CNT_W, 16, width of cycle counters.
- TIMEOUT_CYC, 4096, max RUN cycles per program before forced abort (must be < 2^CNT_W).

Ports:
- CLK  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Go  in  1  start batch; sampled in IDLE only.
- Abort  in  1  synchronous abort of the batch; valid in any state.
- Addr_Table  in  NUM_PROGS*ADDR_W  start addresses; entry i is in bits [i*ADDR_W +: ADDR_W]; latched on accepted Go.
- Halt  in  1  core reports the current program finished; level.
- Start  out  1  one-cycle pulse to the fetch unit Start input.
- Start_Addr  out  ADDR_W  address for the fetch unit; valid while Start=1, held otherwise.
- Prog_Idx  out  3  index of the program currently launched or running.
- Busy  out  1  high in every state except IDLE.
- Done_All  out  1  batch complete; level.
- Timeout  out  1  sticky; at least one program in the batch hit TIMEOUT_CYC.
- Cycle_Count  out  CNT_W  RUN cycles elapsed for the current program.
- Last_Cycles  out  CNT_W  final Cycle_Count of the most recently finished program.

Behaviour:
- Reset (Reset_n=0, asynchronous)
  - State=IDLE.
  - Start=0, Start_Addr=0, Prog_Idx=0, Busy=0, Done_All=0, Timeout=0, Cycle_Count=0, Last_Cycles=0.
  - Latched table=0.
- All outputs are registered. The state register has five states: IDLE, LAUNCH, RUN, GAP, FIN.
- IDLE
  - Go=1 latches Addr_Table, sets Prog_Idx=0, clears Done_All and Timeout, then moves to LAUNCH.
  - Otherwise the block holds.
- LAUNCH (exactly 1 cycle)
  - Start=1 and Start_Addr=table[Prog_Idx].
  - Cycle_Count=0. Halt is ignored.
  - Next state is RUN.
- RUN
  - Cycle_Count increments by 1 each cycle; the first RUN cycle shows 1.
  - Halt=1: Last_Cycles<=Cycle_Count. Move to FIN if Prog_Idx==NUM_PROGS-1, else to GAP.
  - Halt=0 with Cycle_Count==TIMEOUT_CYC: Timeout<=1, Last_Cycles<=TIMEOUT_CYC, then the same next-state rule as Halt.
  - Halt=1 and the timeout condition in the same cycle: Halt wins and Timeout is not set.
- GAP (exactly 1 cycle)
  - Halt is ignored; this lets the core's Halt deassert.
  - Prog_Idx<=Prog_Idx+1, then move to LAUNCH.
- FIN (1 cycle)
  - Done_All<=1, then move to IDLE.
  - Done_All stays high in IDLE until the next accepted Go.
- Start is 0 in every state except LAUNCH. Start_Addr holds its last value outside LAUNCH.
- Busy = (state != IDLE).
- Abort=1 in any state
  - Next state is IDLE, Start=0, Done_All=0.
  - Prog_Idx, Last_Cycles and Timeout are held, for debug.
  - Abort has priority over Go, Halt and the timeout condition.
- Go asserted while Busy is ignored. Go held high across FIN restarts the batch on the first IDLE cycle.
- Latency: Go accepted at edge t gives Start=1 during cycle t+1. Halt sampled at edge t gives the next Start 2 cycles later (GAP, then LAUNCH).
- Cycle_Count never wraps: the timeout check fires first.
- NUM_PROGS=1 goes LAUNCH -> RUN -> FIN with no GAP.
- Reset mid-batch returns every output to its reset value immediately. It does not wait for a clock edge.

Test Plan:
- Reset values: assert Reset_n=0 mid-RUN -> all outputs 0 asynchronously; after release the block sits in IDLE with Busy=0.
- Normal batch: Addr_Table={8'h40,8'h20,8'h00}, Go pulse, Halt after 5, 7 and 3 RUN cycles.
  - Required Start pulses with Start_Addr 00, then 20, then 40, on Prog_Idx 0/1/2.
  - Last_Cycles reads 5, 7, 3 in turn.
  - Done_All=1 one cycle after the final Halt; Timeout=0.
- Timeout: TIMEOUT_CYC=16, program 1 never halts -> Timeout=1 after 16 RUN cycles and Last_Cycles=16. Program 2 still launches and Done_All still rises; Timeout stays 1 until the next Go.
- Simultaneous events:
  - Halt at Cycle_Count==16 -> Timeout stays 0.
  - Halt high during LAUNCH/GAP -> ignored; no early exit from RUN unless Halt is still high in RUN.
- Abort: Abort asserted during program 1 RUN -> IDLE next cycle, Start=0, Busy=0, Done_All=0, Prog_Idx=1 held; a new Go restarts at Prog_Idx=0.
- Go while Busy: pulse Go during RUN -> no re-latch of Addr_Table and no extra Start pulse; the batch completes normally.
